// File: rtl/best_neighbor_scan.sv
// Q-table scanner: walks N three-word entries and tracks fp16 minima of own Q and advertised value.
// Optional BEST_SKIP_SELF_EN: entries carrying this node's own ID never win either minimum.
module best_neighbor_scan #(
  parameter int MAX_NEIGHBORS = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int WORD_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [3:0]            num_neighbors,
  input  logic [ADDR_WIDTH-1:0] table_base,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_data_in,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] _mybest,
  output logic [WORD_WIDTH-1:0] _besthop,
  output logic [WORD_WIDTH-1:0] _bestvalue,
  output logic [WORD_WIDTH-1:0] _bestneighborID
);

  localparam logic [3:0]            MAX_N   = 4'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] POS_INF = WORD_WIDTH'(16'h7C00);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_RD_Q, S_RD_ADV, S_UPDATE, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [3:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] id_q, id_d;
  logic [WORD_WIDTH-1:0] qv_q, qv_d;
  logic [WORD_WIDTH-1:0] min_own_q, min_own_d;
  logic [WORD_WIDTH-1:0] own_id_q, own_id_d;
  logic [WORD_WIDTH-1:0] min_adv_q, min_adv_d;
  logic [WORD_WIDTH-1:0] adv_id_q, adv_id_d;
  logic [WORD_WIDTH-1:0] mybest_q, mybest_d;
  logic [WORD_WIDTH-1:0] besthop_q, besthop_d;
  logic [WORD_WIDTH-1:0] bestvalue_q, bestvalue_d;
  logic [WORD_WIDTH-1:0] bestnid_q, bestnid_d;
  logic [3:0]            n_clamped;
  logic                  eligible;

  // Strict fp16 a < b; +0 and -0 compare equal, NaN handled by bit pattern.
  function automatic logic fp_lt(input logic [WORD_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] b);
    if (a[WORD_WIDTH-1] != b[WORD_WIDTH-1])
      return a[WORD_WIDTH-1] && !((a[WORD_WIDTH-2:0] == '0) && (b[WORD_WIDTH-2:0] == '0));
    else if (!a[WORD_WIDTH-1])
      return a[WORD_WIDTH-2:0] < b[WORD_WIDTH-2:0];
    else
      return a[WORD_WIDTH-2:0] > b[WORD_WIDTH-2:0];
  endfunction

  assign n_clamped = (num_neighbors > MAX_N) ? MAX_N : num_neighbors;

`ifdef BEST_SKIP_SELF_EN
  assign eligible = (id_q != MY_NODE_ID);
`else
  assign eligible = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    id_d        = id_q;
    qv_d        = qv_q;
    min_own_d   = min_own_q;
    own_id_d    = own_id_q;
    min_adv_d   = min_adv_q;
    adv_id_d    = adv_id_q;
    mybest_d    = mybest_q;
    besthop_d   = besthop_q;
    bestvalue_d = bestvalue_q;
    bestnid_d   = bestnid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = n_clamped;
          idx_d     = '0;
          min_own_d = POS_INF;
          own_id_d  = MY_NODE_ID;
          min_adv_d = POS_INF;
          adv_id_d  = MY_NODE_ID;
          if (n_clamped != '0) begin
            state_d = S_RD_ID;
            addr_d  = table_base;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD_ID: begin
        state_d = S_RD_Q;
        addr_d  = addr_q + 1'b1;
      end
      S_RD_Q: begin
        id_d    = mem_data_in;
        state_d = S_RD_ADV;
        addr_d  = addr_q + 1'b1;
      end
      S_RD_ADV: begin
        qv_d    = mem_data_in;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (eligible && fp_lt(qv_q, min_own_q)) begin
          min_own_d = qv_q;
          own_id_d  = id_q;
        end
        if (eligible && fp_lt(mem_data_in, min_adv_q)) begin
          min_adv_d = mem_data_in;
          adv_id_d  = id_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_d == n_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD_ID;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Publish on entry to DONE so results are already stable while done is high.
    if (state_d == S_DONE) begin
      mybest_d    = min_own_d;
      besthop_d   = own_id_d;
      bestvalue_d = min_adv_d;
      bestnid_d   = adv_id_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      qv_q        <= '0;
      min_own_q   <= POS_INF;
      own_id_q    <= '0;
      min_adv_q   <= POS_INF;
      adv_id_q    <= '0;
      mybest_q    <= POS_INF;
      besthop_q   <= '0;
      bestvalue_q <= POS_INF;
      bestnid_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      qv_q        <= qv_d;
      min_own_q   <= min_own_d;
      own_id_q    <= own_id_d;
      min_adv_q   <= min_adv_d;
      adv_id_q    <= adv_id_d;
      mybest_q    <= mybest_d;
      besthop_q   <= besthop_d;
      bestvalue_q <= bestvalue_d;
      bestnid_q   <= bestnid_d;
    end
  end

  assign mem_rd_en       = (state_q == S_RD_ID) || (state_q == S_RD_Q) || (state_q == S_RD_ADV);
  assign mem_addr        = addr_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign _mybest         = mybest_q;
  assign _besthop        = besthop_q;
  assign _bestvalue      = bestvalue_q;
  assign _bestneighborID = bestnid_q;

endmodule

// File: tb/tb_best_neighbor_scan.sv
// Directed bench for best_neighbor_scan with a registered-read word memory model.
module tb_best_neighbor_scan;
  logic        clock = 1'b0;
  logic        nreset, start;
  logic [3:0]  num_neighbors;
  logic [9:0]  table_base;
  logic [15:0] MY_NODE_ID;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data_in;
  logic        busy, done;
  logic [15:0] _mybest, _besthop, _bestvalue, _bestneighborID;

  logic [15:0] mem [0:1023];
  logic [9:0]  addr_log [0:4095];
  int          rd_count = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  best_neighbor_scan dut (
    .clock(clock), .nreset(nreset), .start(start), .num_neighbors(num_neighbors),
    .table_base(table_base), .MY_NODE_ID(MY_NODE_ID), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .busy(busy), .done(done),
    ._mybest(_mybest), ._besthop(_besthop), ._bestvalue(_bestvalue),
    ._bestneighborID(_bestneighborID)
  );

  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_data_in        <= mem[mem_addr];
      addr_log[rd_count] <= mem_addr;
      rd_count           <= rd_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic put_entry(input int base, input int i, input logic [15:0] id,
                           input logic [15:0] q, input logic [15:0] adv);
    mem[(base + 3*i) % 1024]     = id;
    mem[(base + 3*i + 1) % 1024] = q;
    mem[(base + 3*i + 2) % 1024] = adv;
  endtask

  task automatic check_results(input string tag, input logic [15:0] mb, input logic [15:0] bh,
                               input logic [15:0] bv, input logic [15:0] bn);
    check_eq({tag, "_mybest"}, 32'(_mybest), 32'(mb));
    check_eq({tag, "_besthop"}, 32'(_besthop), 32'(bh));
    check_eq({tag, "_bestvalue"}, 32'(_bestvalue), 32'(bv));
    check_eq({tag, "_bestnid"}, 32'(_bestneighborID), 32'(bn));
  endtask

  // Returns edges counted from the start-sampling edge (inclusive) to the edge raising done.
  task automatic run_scan(input logic [3:0] n, input logic [9:0] base, input bit glitch,
                          output int lat);
    int edges;
    @(negedge clock);
    num_neighbors = n;
    table_base    = base;
    start         = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 200) begin
      if (glitch && edges == 5) begin
        start = 1'b1;
        num_neighbors = 4'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      edges++;
    end
    start = 1'b0;
    lat = edges;
    check_eq("busy_in_done", 32'(busy), 'h1);
    start = 1'b1;
    num_neighbors = 4'd1;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("done_one_cycle", 32'(done), 'h0);
    check_eq("start_in_done_ignored", 32'(busy), 'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, log0, seen;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    nreset = 1'b0; start = 1'b0; num_neighbors = 4'd0; table_base = 10'd0;
    MY_NODE_ID = 16'h0042;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", 32'(busy), 'h0);
    check_eq("rst_done", 32'(done), 'h0);
    check_eq("rst_rd_en", 32'(mem_rd_en), 'h0);
    check_eq("rst_addr", 32'(mem_addr), 'h0);
    check_results("rst", 16'h7C00, 16'h0000, 16'h7C00, 16'h0000);
    @(negedge clock) nreset = 1'b1;

    // Basic three-entry scan
    put_entry('h010, 0, 16'd5, 16'h3C00, 16'h4000);
    put_entry('h010, 1, 16'd7, 16'h3800, 16'h4400);
    put_entry('h010, 2, 16'd9, 16'h4000, 16'h3C00);
    log0 = rd_count;
    run_scan(4'd3, 10'h010, 1'b0, lat);
    check_eq("t1_latency", 32'(lat), 13);
    check_results("t1", 16'h3800, 16'd7, 16'h3C00, 16'd9);
    check_eq("t1_reads", 32'(rd_count - log0), 9);
    for (int k = 0; k < 9; k++) check_eq($sformatf("t1_addr%0d", k), 32'(addr_log[log0 + k]), 'h010 + k);

    // Empty table
    log0 = rd_count;
    run_scan(4'd0, 10'h050, 1'b0, lat);
    check_eq("t2_latency", 32'(lat), 1);
    check_eq("t2_no_reads", 32'(rd_count - log0), 0);
    check_results("t2", 16'h7C00, 16'h0042, 16'h7C00, 16'h0042);

    // Negative values, -0 vs -1, tie keeps first; +0 then -0 keeps first
    put_entry('h100, 0, 16'd1, 16'hBC00, 16'h0000);
    put_entry('h100, 1, 16'd2, 16'h8000, 16'h8000);
    put_entry('h100, 2, 16'd3, 16'hBC00, 16'h3C00);
    run_scan(4'd3, 10'h100, 1'b0, lat);
    check_results("t3a", 16'hBC00, 16'd1, 16'h0000, 16'd1);

    // +0 then -0 then negative for own Q; -0 then +0 then +inf for advertised
    put_entry('h200, 0, 16'd4, 16'h0000, 16'h8000);
    put_entry('h200, 1, 16'd6, 16'h8000, 16'h0000);
    put_entry('h200, 2, 16'd8, 16'hC000, 16'h7C00);
    run_scan(4'd3, 10'h200, 1'b0, lat);
    check_results("t3b", 16'hC000, 16'd8, 16'h8000, 16'd4);

    // Address wrap
    put_entry('h3FE, 0, 16'h0011, 16'h4200, 16'h4800);
    put_entry('h3FE, 1, 16'h0012, 16'h4100, 16'h4900);
    log0 = rd_count;
    run_scan(4'd2, 10'h3FE, 1'b0, lat);
    check_eq("t4_latency", 32'(lat), 9);
    check_results("t4", 16'h4100, 16'h0012, 16'h4800, 16'h0011);
    for (int k = 0; k < 6; k++)
      check_eq($sformatf("t4_addr%0d", k), 32'(addr_log[log0 + k]), 32'((10'h3FE + 10'(k)) & 10'h3FF));

    // Reset during RD_Q of entry 2 of 4
    put_entry('h300, 0, 16'h0021, 16'h4400, 16'h4400);
    put_entry('h300, 1, 16'h0022, 16'h4300, 16'h4600);
    put_entry('h300, 2, 16'h0023, 16'h4500, 16'h4200);
    put_entry('h300, 3, 16'h0024, 16'h4380, 16'h4300);
    @(negedge clock);
    num_neighbors = 4'd4; table_base = 10'h300; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 0;
    repeat (9) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    check_eq("t5_mid_busy", 32'(busy), 'h1);
    check_eq("t5_mid_addr", 32'(mem_addr), 'h307);
    nreset = 1'b0;
    @(posedge clock); #1;
    if (done) seen++;
    check_eq("t5_rst_busy", 32'(busy), 'h0);
    check_eq("t5_rst_rd_en", 32'(mem_rd_en), 'h0);
    check_eq("t5_rst_addr", 32'(mem_addr), 'h0);
    check_results("t5_rst", 16'h7C00, 16'h0000, 16'h7C00, 16'h0000);
    repeat (3) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    check_eq("t5_no_done", 32'(seen), 0);
    @(negedge clock) nreset = 1'b1;
    run_scan(4'd4, 10'h300, 1'b0, lat);
    check_eq("t5_latency", 32'(lat), 17);
    check_results("t5", 16'h4300, 16'h0022, 16'h4200, 16'h0023);

    // Own ID in table, with start pulsed mid-scan
    MY_NODE_ID = 16'd7;
    run_scan(4'd3, 10'h010, 1'b1, lat);
    check_eq("t6_latency", 32'(lat), 13);
`ifdef BEST_SKIP_SELF_EN
    check_results("t6", 16'h3C00, 16'd5, 16'h3C00, 16'd9);
`else
    check_results("t6", 16'h3800, 16'd7, 16'h3C00, 16'd9);
`endif

    // Nothing beats +inf
    MY_NODE_ID = 16'h0042;
    put_entry('h180, 0, 16'h0033, 16'h7C00, 16'h7C00);
    run_scan(4'd1, 10'h180, 1'b0, lat);
    check_eq("t7_latency", 32'(lat), 5);
    check_results("t7", 16'h7C00, 16'h0042, 16'h7C00, 16'h0042);

    // Count above MAX_NEIGHBORS clamps to 8; entries 8..11 would otherwise win
    for (int i = 0; i < 12; i++) begin
      if (i < 8) put_entry('h380, i, 16'(16'h0040 + i), 16'(16'h5000 - i), 16'(16'h3000 + i));
      else       put_entry('h380, i, 16'(16'h0040 + i), 16'h1000, 16'h1000);
    end
    log0 = rd_count;
    run_scan(4'd12, 10'h380, 1'b0, lat);
    check_eq("t8_latency", 32'(lat), 33);
    check_eq("t8_reads", 32'(rd_count - log0), 24);
    check_results("t8", 16'h4FF9, 16'h0047, 16'h3000, 16'h0040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
